uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter for the 115200-baud debug/host link. It is the transmit counterpart of the board's UART receive path.
- Accepts bytes from the core or debug logic over a valid/ready handshake. Buffers them in a small FIFO.
- Shifts each byte out as an 8N1 frame: 1 start bit, NUM_DATA_BITS data bits LSB first, 1 stop bit, no parity.
- Sits between the memory-mapped I/O / ILA readout logic and the board TX pin.

Parameters:
CLKS_PER_BIT, BAUD_COUNT_CHECK (868 at 100 MHz / 115200), clock cycles per serial bit; must be >= 2
NUM_DATA_BITS, 8, data bits per frame
FIFO_DEPTH, 4, byte buffer entries; power of two, >= 2

Ports:
clk  in  1  system clock (FREQUENCY_IN_HZ)
reset  in  1  asynchronous, active-low reset (asserted when equal to RESET = 1'b0)
tx_data  in  NUM_DATA_BITS  byte to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  FIFO can accept a byte; high iff FIFO not full
tx  out  1  serial line, idle high
busy  out  1  high while a frame is on the line or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0, asynchronous), all outputs registered:
  - tx=1, tx_ready=1, busy=0, fifo_count=0.
  - FSM in IDLE; FIFO pointers, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high and buffered bytes are discarded.
- Handshake:
  - Byte is written into FIFO on a rising edge where tx_valid && tx_ready.
  - tx_ready = !full, registered-equivalent (a function of fifo_count only). It never depends combinationally on tx_valid.
  - A push while full is impossible, because tx_ready=0. A same-cycle pop does not enable a push in that cycle.
  - tx_data is sampled only on the accepting edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty: pop the head into the shift register, load baud counter, drive tx=0, go to START. Pop and state change occur on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After NUM_DATA_BITS bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Timing:
  - Byte accepted at edge E0 with FSM IDLE and FIFO empty: tx goes low at edge E1 (one cycle of latency).
  - Frame length is exactly (NUM_DATA_BITS+2)*CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. No fractional-bit drift is allowed.
- FIFO:
  - Circular buffer with pointer wrap at FIFO_DEPTH.
  - Simultaneous push and pop: fifo_count unchanged, ordering preserved.
  - Pop only when non-empty.
- busy = (state != IDLE) || (fifo_count != 0).
- tx is glitch-free: driven from a flop.

Test Plan:
- Reset idle (CLKS_PER_BIT=4): release reset, hold tx_valid=0 for 100 cycles -> tx=1, busy=0, tx_ready=1, fifo_count=0 throughout.
- Single byte 0xA5: push at E0 -> tx low from E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; frame is 40 cycles; busy falls the cycle after STOP ends.
- Back-to-back: push 0x00, 0xFF, 0x55, 0x0F, 0x81 consecutively -> tx_ready drops when fifo_count reaches 4; the 5th byte is accepted once the first pop frees a slot; five frames appear contiguously (200 cycles, no idle gap); the serial decoder in the bench checks all bytes in order.
- Full-FIFO backpressure: hold tx_valid=1 with incrementing data while the FIFO is full and simultaneously popped -> no byte is lost or duplicated; fifo_count never exceeds 4.
- Reset mid-frame: assert reset during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 asynchronously, fifo_count=0; after release no residual frame is sent.
- Default parameters: CLKS_PER_BIT=868, byte 0x55 -> each bit lasts exactly 868 cycles; frame is 8680 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between a producer and the UART transmitter
interface uart_tx_if #(
    parameter int W = 8
);
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter, LSB first, idle-high line
module uart_tx #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int NUM_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_if.slave                    bus,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(NUM_DATA_BITS) + 1;
    localparam logic [AW:0]   FULL    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_MAX = BW'(NUM_DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                   state, state_d;
    logic [CW-1:0]            cnt, cnt_d;
    logic [BW-1:0]            idx, idx_d;
    logic [NUM_DATA_BITS-1:0] shift, shift_d;
    logic [NUM_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic                     tx_d, push, pop, bit_end, last;

    assign bus.tx_ready = fifo_count != FULL;
    assign busy         = state != IDLE || fifo_count != '0;
    assign push         = bus.tx_valid && bus.tx_ready;
    assign bit_end      = cnt == CNT_MAX;
    assign last         = idx == IDX_MAX;
    assign pop          = fifo_count != '0 && (state == IDLE || (state == STOP && bit_end));

    // frame state, baud/bit counters, shift register and the flopped line driver
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shift <= shift_d;
            tx    <= tx_d;
        end
    end

    // next frame state; a pop always starts a frame, otherwise advance on bit boundaries
    always_comb begin
        state_d = pop ? START :
                  !bit_end ? state :
                  state == START ? DATA :
                  state == DATA ? (last ? STOP : DATA) : IDLE;
    end

    // next datapath values; tx follows the next state so the line changes with the state
    always_comb begin
        cnt_d   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
        idx_d   = (state != DATA || (bit_end && last)) ? '0 : bit_end ? idx + 1'b1 : idx;
        shift_d = pop ? mem[rd_ptr] : (state == DATA && bit_end) ? shift >> 1 : shift;
        tx_d    = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    end

    // circular FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= (push && !pop) ? fifo_count + 1'b1 :
                          (pop && !push) ? fifo_count - 1'b1 : fifo_count;
        end
    end

    // FIFO storage, written only on an accepting edge
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.tx_data;
    end
endmodule
